// File: rtl/inst_loop_sequencer.sv
// Loop sequencer: expands one loop descriptor into a series of strided
// instructions, handshaking each one with the systolic array via idle_flag/flag.
module inst_loop_sequencer #(
    parameter int OPCODE_BITS    = 4,
    parameter int ADDR_BITS      = 16,
    parameter int CNT_BITS       = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [OPCODE_BITS-1:0]             cmd_opcode,
    input  logic [ADDR_BITS-1:0]               cmd_addra_base,
    input  logic [ADDR_BITS-1:0]               cmd_addrb_base,
    input  logic [ADDR_BITS-1:0]               cmd_stride_a,
    input  logic [ADDR_BITS-1:0]               cmd_stride_b,
    input  logic [CNT_BITS-1:0]                cmd_count,
    input  logic                               abort,
    output logic                               init_inst_pulse,
    output logic [OPCODE_BITS+2*ADDR_BITS-1:0] instruction,
    input  logic                               idle_flag,
    input  logic                               flag,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [CNT_BITS-1:0]                issued_cnt
);

    localparam int WD_BITS = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_BITS-1:0] WD_LAST =
        WD_BITS'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FIN} state_t;

    state_t                 state_reg, state_next;
    logic [OPCODE_BITS-1:0] opcode_reg;
    logic [ADDR_BITS-1:0]   addra_reg, addrb_reg;
    logic [ADDR_BITS-1:0]   stride_a_reg, stride_b_reg;
    logic [CNT_BITS-1:0]    count_reg, issued_cnt_reg;
    logic [CNT_BITS-1:0]    issued_inc;
    logic [WD_BITS-1:0]     wd_cnt_reg;
    logic                   abort_pending_reg, error_reg;
    logic                   accept, complete, abort_seen, wd_expired;

    assign issued_inc = issued_cnt_reg + CNT_BITS'(1);
    assign accept     = (state_reg == IDLE) && cmd_valid;
    assign complete   = (state_reg == WAIT) && flag;
    assign abort_seen = abort_pending_reg || abort;
    assign wd_expired = WD_EN && ((state_reg == ISSUE) || (state_reg == WAIT)) &&
                        (wd_cnt_reg == WD_LAST);

    assign instruction = {opcode_reg, addra_reg, addrb_reg};
    assign error       = error_reg;
    assign issued_cnt  = issued_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Outputs decode straight from the state so reset removes them asynchronously.
    always_comb begin
        state_next      = state_reg;
        cmd_ready       = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        init_inst_pulse = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    state_next = (cmd_count == '0) ? FIN : ISSUE;
            end
            ISSUE: begin
                init_inst_pulse = 1'b1;
                if (wd_expired)     state_next = FIN;
                else if (!idle_flag) state_next = WAIT;
            end
            WAIT: begin
                // A completion in the expiry cycle still counts as a completion.
                if (flag)
                    state_next = ((issued_inc == count_reg) || abort_seen) ? FIN : GAP;
                else if (wd_expired)
                    state_next = FIN;
            end
            GAP: begin
                if (abort_seen)                state_next = FIN;
                else if (idle_flag && !flag)   state_next = ISSUE;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_reg        <= '0;
            addra_reg         <= '0;
            addrb_reg         <= '0;
            stride_a_reg      <= '0;
            stride_b_reg      <= '0;
            count_reg         <= '0;
            issued_cnt_reg    <= '0;
            wd_cnt_reg        <= '0;
            abort_pending_reg <= 1'b0;
            error_reg         <= 1'b0;
        end else if (accept) begin
            opcode_reg        <= cmd_opcode;
            addra_reg         <= cmd_addra_base;
            addrb_reg         <= cmd_addrb_base;
            stride_a_reg      <= cmd_stride_a;
            stride_b_reg      <= cmd_stride_b;
            count_reg         <= cmd_count;
            issued_cnt_reg    <= '0;
            wd_cnt_reg        <= '0;
            abort_pending_reg <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            if (state_reg == IDLE) abort_pending_reg <= 1'b0;
            else if (abort)        abort_pending_reg <= 1'b1;

            if (complete) begin
                issued_cnt_reg <= issued_inc;
                addra_reg      <= addra_reg + stride_a_reg;
                addrb_reg      <= addrb_reg + stride_b_reg;
                wd_cnt_reg     <= '0;
            end else if (wd_expired) begin
                error_reg  <= 1'b1;
                wd_cnt_reg <= '0;
            end else if (WD_EN && ((state_reg == ISSUE) || (state_reg == WAIT))) begin
                wd_cnt_reg <= wd_cnt_reg + WD_BITS'(1);
            end else begin
                wd_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_inst_loop_sequencer.sv
// Directed bench for inst_loop_sequencer with a small behavioural array model.
module tb_inst_loop_sequencer;

    localparam int OB = 4;
    localparam int AB = 16;
    localparam int CB = 10;
    localparam int IW = OB + 2 * AB;
    localparam logic [OB-1:0] AXI_TO_UB = 4'h1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [OB-1:0] cmd_opcode = '0;
    logic [AB-1:0] cmd_addra_base = '0, cmd_addrb_base = '0;
    logic [AB-1:0] cmd_stride_a = '0, cmd_stride_b = '0;
    logic [CB-1:0] cmd_count = '0;
    logic          abort = 1'b0;
    logic          init_inst_pulse;
    logic [IW-1:0] instruction;
    logic          idle_flag = 1'b1;
    logic          flag = 1'b0;
    logic          busy, done, error;
    logic [CB-1:0] issued_cnt;

    int checks = 0;
    int errors = 0;
    bit model_en = 1'b1;
    int done_seen = 0;
    logic [IW-1:0] issued_q[$];

    always #5 clk = ~clk;

    inst_loop_sequencer #(
        .OPCODE_BITS(OB), .ADDR_BITS(AB), .CNT_BITS(CB), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_addra_base(cmd_addra_base), .cmd_addrb_base(cmd_addrb_base),
        .cmd_stride_a(cmd_stride_a), .cmd_stride_b(cmd_stride_b),
        .cmd_count(cmd_count), .abort(abort),
        .init_inst_pulse(init_inst_pulse), .instruction(instruction),
        .idle_flag(idle_flag), .flag(flag),
        .busy(busy), .done(done), .error(error), .issued_cnt(issued_cnt)
    );

    // Array model: takes the request, goes busy, raises flag for one cycle, returns idle.
    initial begin
        forever begin
            @(negedge clk);
            if (model_en && reset_n && init_inst_pulse && idle_flag) begin
                issued_q.push_back(instruction);
                $display("issue op=%h a=%h b=%h", instruction[IW-1 -: OB],
                         instruction[2*AB-1 -: AB], instruction[AB-1:0]);
                idle_flag = 1'b0;
                repeat (2) @(negedge clk);
                flag = 1'b1;
                @(negedge clk);
                flag = 1'b0;
                idle_flag = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_seen++;
        end
    end

    task automatic send_cmd(input logic [OB-1:0] op, input logic [AB-1:0] a, input logic [AB-1:0] b,
                            input logic [AB-1:0] sa, input logic [AB-1:0] sb, input logic [CB-1:0] n);
        @(negedge clk);
        cmd_opcode = op; cmd_addra_base = a; cmd_addrb_base = b;
        cmd_stride_a = sa; cmd_stride_b = sb; cmd_count = n;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd op=%h a=%h b=%h sa=%h sb=%h count=%0d", op, a, b, sa, sb, n);
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (init_inst_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", init_inst_pulse); end
        checks++; if (instruction !== '0) begin errors++; $display("FAIL reset_instruction: got %h want 0", instruction); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b error=%b want 000", busy, done, error); end
        checks++; if (issued_cnt !== '0) begin errors++; $display("FAIL reset_issued: got %0d want 0", issued_cnt); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ascending;
        bit ok;
        logic [IW-1:0] exp;
        issued_q.delete();
        send_cmd(AXI_TO_UB, 16'd0, 16'd0, 16'd1, 16'd16, 10'd4);
        checks++; if (init_inst_pulse !== 1'b1) begin errors++; $display("FAIL asc_first_pulse_latency: got %b want 1", init_inst_pulse); end
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL asc_busy: ready=%b busy=%b want 0 1", cmd_ready, busy); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL asc_done_timeout: done never seen"); end
        checks++; if (issued_cnt !== 10'd4) begin errors++; $display("FAIL asc_issued: got %0d want 4", issued_cnt); end
        checks++; if (issued_q.size() != 4) begin errors++; $display("FAIL asc_count: got %0d want 4", issued_q.size()); end
        for (int i = 0; i < 4 && i < issued_q.size(); i++) begin
            exp = {AXI_TO_UB, 16'(i), 16'(16 * i)};
            checks++; if (issued_q[i] !== exp) begin errors++; $display("FAIL asc_inst%0d: got %h want %h", i, issued_q[i], exp); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL asc_after_done: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_descending;
        bit ok;
        logic [AB-1:0] exp_b[3];
        exp_b[0] = 16'h0010; exp_b[1] = 16'h0000; exp_b[2] = 16'hFFF0;
        issued_q.delete();
        send_cmd(4'h2, 16'h0005, 16'h0010, 16'h0000, 16'hFFF0, 10'd3);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL desc_done_timeout: done never seen"); end
        checks++; if (issued_q.size() != 3) begin errors++; $display("FAIL desc_count: got %0d want 3", issued_q.size()); end
        for (int i = 0; i < 3 && i < issued_q.size(); i++) begin
            checks++; if (issued_q[i] !== {4'h2, 16'h0005, exp_b[i]}) begin errors++; $display("FAIL desc_inst%0d: got %h want %h", i, issued_q[i], {4'h2, 16'h0005, exp_b[i]}); end
        end
    endtask

    task automatic test_zero_count;
        issued_q.delete();
        send_cmd(4'h3, 16'h1234, 16'h5678, 16'd1, 16'd1, 10'd0);
        checks++; if (done !== 1'b1 || init_inst_pulse !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b pulse=%b want 1 0", done, init_inst_pulse); end
        checks++; if (issued_cnt !== '0) begin errors++; $display("FAIL zero_issued: got %0d want 0", issued_cnt); end
        repeat (4) @(negedge clk);
        checks++; if (issued_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL zero_no_pulse: pulses=%0d busy=%b want 0 0", issued_q.size(), busy); end
    endtask

    task automatic test_abort;
        bit ok;
        bit seen;
        issued_q.delete();
        send_cmd(4'h4, 16'd0, 16'd0, 16'd1, 16'd1, 10'd5);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (issued_q.size() >= 2) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_second_timeout: pulses=%0d want 2", issued_q.size()); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_done_timeout: done never seen"); end
        checks++; if (issued_cnt !== 10'd2) begin errors++; $display("FAIL abort_issued: got %0d want 2", issued_cnt); end
        repeat (8) @(negedge clk);
        checks++; if (issued_q.size() != 2) begin errors++; $display("FAIL abort_no_third: pulses=%0d want 2", issued_q.size()); end
    endtask

    task automatic test_ignore_busy;
        bit ok;
        int done_before;
        issued_q.delete();
        send_cmd(4'h5, 16'd10, 16'd20, 16'd1, 16'd1, 10'd2);
        // A second descriptor offered while busy must be dropped, not queued.
        cmd_opcode = 4'h6; cmd_count = 10'd3; cmd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(100, ok);
        checks++; if (!ok || issued_cnt !== 10'd2) begin errors++; $display("FAIL busy_issued: done=%b got %0d want 2", ok, issued_cnt); end
        done_before = done_seen;
        repeat (10) @(negedge clk);
        checks++; if (issued_q.size() != 2 || busy !== 1'b0 || done_seen != done_before) begin errors++; $display("FAIL busy_not_queued: pulses=%0d busy=%b want 2 0", issued_q.size(), busy); end
    endtask

    task automatic test_watchdog;
        bit ok;
        int pulse_cycles;
        model_en = 1'b0;
        issued_q.delete();
        send_cmd(4'h7, 16'd0, 16'd0, 16'd1, 16'd1, 10'd2);
        pulse_cycles = 1;  // pulse already high at the post-accept negedge
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
            if (init_inst_pulse) pulse_cycles++;
        end
        checks++; if (!ok) begin errors++; $display("FAIL wd_done_timeout: done never seen"); end
        checks++; if (pulse_cycles != 8) begin errors++; $display("FAIL wd_pulse_len: got %0d want 8", pulse_cycles); end
        checks++; if (error !== 1'b1 || init_inst_pulse !== 1'b0) begin errors++; $display("FAIL wd_error: error=%b pulse=%b want 1 0", error, init_inst_pulse); end
        checks++; if (issued_cnt !== '0) begin errors++; $display("FAIL wd_issued: got %0d want 0", issued_cnt); end
        repeat (3) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", error); end
        model_en = 1'b1;
        send_cmd(4'h8, 16'd0, 16'd0, 16'd1, 16'd1, 10'd1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL wd_clear_on_accept: got %b want 0", error); end
        wait_done(100, ok);
        checks++; if (!ok || error !== 1'b0 || issued_cnt !== 10'd1) begin errors++; $display("FAIL wd_recover: done=%b error=%b issued=%0d want 1 0 1", ok, error, issued_cnt); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        int done_before;
        issued_q.delete();
        send_cmd(4'h9, 16'd100, 16'd200, 16'd1, 16'd1, 10'd3);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy && !init_inst_pulse && !idle_flag) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_wait_timeout: WAIT never reached"); end
        done_before = done_seen;
        reset_n = 1'b0;
        #1;
        checks++; if (init_inst_pulse !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl: pulse=%b busy=%b ready=%b want 0 0 1", init_inst_pulse, busy, cmd_ready); end
        checks++; if (instruction !== '0 || issued_cnt !== '0 || error !== 1'b0) begin errors++; $display("FAIL rst_mid_data: inst=%h issued=%0d error=%b want 0 0 0", instruction, issued_cnt, error); end
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (done_seen != done_before) begin errors++; $display("FAIL rst_no_done: done pulses=%0d want 0", done_seen - done_before); end
        issued_q.delete();
        send_cmd(4'hA, 16'h00AA, 16'h00BB, 16'd1, 16'd1, 10'd1);
        wait_done(100, ok);
        checks++; if (!ok || issued_cnt !== 10'd1) begin errors++; $display("FAIL rst_new_loop: done=%b issued=%0d want 1 1", ok, issued_cnt); end
        checks++; if (issued_q.size() != 1 || (issued_q.size() == 1 && issued_q[0] !== {4'hA, 16'h00AA, 16'h00BB})) begin errors++; $display("FAIL rst_new_inst: pulses=%0d want 1 with a00aa00bb", issued_q.size()); end
    endtask

    initial begin
        test_reset;
        test_ascending;
        test_descending;
        test_zero_count;
        test_abort;
        test_ignore_busy;
        test_watchdog;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
